if_pc_gen_btb: RTL and testbench
================================

Name: if_pc_gen_btb

Overview:
Parametrised instruction-fetch PC generator for the in-order pipeline. It replaces the fixed next-PC logic with a direct-mapped branch target buffer (BTB) that has 2-bit saturating counters. It produces the fetch PC every cycle, predicts taken branches at fetch, and accepts redirects and BTB training from the execute stage. It sits at the head of the pipeline and drives IMEM address and the IF/ID register.

Parameters:
XLEN, 32, PC/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
BTB_ENTRIES, 16, number of BTB entries; must be a power of 2 and at least 2
INST_BYTES, 4, fetch step in bytes; PC low log2(INST_BYTES) bits are always 0

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC (load-use hazard / IMEM not ready)
redirect_valid  in  1  execute-stage redirect (mispredict or flush)
redirect_pc  in  XLEN  redirect target
upd_valid  in  1  BTB training strobe from execute, for a resolved branch or jump
upd_pc  in  XLEN  PC of the resolved branch
upd_target  in  XLEN  resolved target
upd_taken  in  1  resolved direction
pc_o  out  XLEN  current fetch PC (registered)
pred_taken_o  out  1  BTB predicts the current pc_o is taken (combinational from pc_o and BTB state)
pred_target_o  out  XLEN  predicted target; 0 when pred_taken_o=0
fetch_valid_o  out  1  registered; 0 in the first cycle after reset or redirect, 1 otherwise

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc_o<=RESET_PC and fetch_valid_o<=0.
  - All BTB valid bits are cleared in that single cycle.
  - BTB target and counter contents are don't-care.
- Next-PC priority, evaluated each edge, highest first:
  1. rst
  2. redirect_valid -> redirect_pc
  3. stall -> hold
  4. pred_taken_o -> pred_target_o
  5. otherwise pc_o+INST_BYTES
- redirect_valid overrides stall.
- Alignment: the low log2(INST_BYTES) bits of redirect_pc and upd_target are forced to 0 before use.
- Arithmetic: pc_o+INST_BYTES wraps modulo 2^XLEN. No overflow flag.
- fetch_valid_o:
  - 0 after an rst edge or a redirect edge.
  - Otherwise 1, including while stalled. The consumer qualifies it with its own stall.
- BTB indexing: IDX=log2(BTB_ENTRIES).
  - index = pc[IDX+log2(INST_BYTES)-1 : log2(INST_BYTES)].
  - tag = the remaining upper PC bits.
  - Each entry holds {valid, tag, target, ctr[1:0]}.
- Lookup: hit = valid && tag match on pc_o. pred_taken_o = hit && ctr[1].
- Update (upd_valid=1, performed at the edge):
  - Hit on upd_pc: ctr saturating +1 if upd_taken, else saturating -1 (range 0..3). Target is rewritten with upd_target when upd_taken.
  - Miss and upd_taken: allocate the entry, overwriting any alias, with valid=1, new tag, target, ctr=2 (weakly taken).
  - Miss and !upd_taken: no change.
- Training is accepted during stall and during redirect. It is ignored when rst=1.
- Same-cycle lookup and update to the same index: the lookup uses the pre-update contents (read-before-write). The new contents are visible next cycle.
- Counter encoding:
  - 0 = strong not-taken, 1 = weak not-taken, 2 = weak taken, 3 = strong taken.
- Reset mid-operation: any in-flight redirect, stall or update in the rst cycle is discarded.

Decomposition:
- Shared package if_pkg holds:
  - the counter constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - a function ctr_next(ctr, taken) implementing saturating update;
  - the INST_BYTES-derived shift constant.
- One sub-module, if_btb: the storage array with combinational lookup port and edge-triggered update port.
- The top level (if_pc_gen_btb) holds the PC register, priority mux and fetch_valid_o.

Test Plan:
- Reset then free-run, RESET_PC=0x100 -> pc_o sequence 0x100, 0x104, 0x108 with fetch_valid_o 0,1,1; pred_taken_o=0 throughout.
- stall=1 with redirect_valid=1, redirect_pc=0x203 in the same cycle -> next pc_o=0x200 (aligned), fetch_valid_o=0; stall alone for 3 cycles -> pc_o held.
- Train upd_pc=0x10, target 0x80, taken -> later, when pc_o=0x10: pred_taken_o=1, pred_target_o=0x80, next pc_o=0x80.
- Counter hysteresis on 0x10:
  - from ctr=2, one not-taken update -> ctr=1, pred_taken_o=0;
  - two taken updates -> ctr=3;
  - one not-taken -> ctr=2, still predicts taken.
- Alias, BTB_ENTRIES=16: entry for 0x10, then a taken update for 0x50 (same index) -> 0x10 misses and 0x50 hits. A not-taken update for an unmapped PC leaves the BTB unchanged.
- pc_o=0xFFFF_FFFC with no prediction -> next pc_o=0x0000_0000; simultaneous update and lookup on the same index -> old prediction this cycle, new one the next.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared definitions for the instruction-fetch PC generator.
//   - 2-bit saturating branch counter encoding and its update function
//   - helper that turns the fetch step (bytes) into the PC alignment shift
package if_pkg;

  // Counter encoding: MSB set means "predict taken".
  localparam logic [1:0] CTR_SNT = 2'd0;  // strong not-taken
  localparam logic [1:0] CTR_WNT = 2'd1;  // weak not-taken
  localparam logic [1:0] CTR_WT  = 2'd2;  // weak taken
  localparam logic [1:0] CTR_ST  = 2'd3;  // strong taken

  // Fetch step assumed by the default configuration.
  localparam int unsigned DEFAULT_INST_BYTES = 32'd4;

  // Number of always-zero low PC bits for a given fetch step.
  function automatic int unsigned inst_shift(input int unsigned inst_bytes);
    return $clog2(inst_bytes);
  endfunction

  // Alignment shift for the default fetch step.
  localparam int unsigned INST_SHIFT = inst_shift(DEFAULT_INST_BYTES);

  // Saturating counter step: +1 on taken, -1 on not-taken, clamped to 0..3.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case ({taken, ctr})
      {1'b1, CTR_SNT}: nxt = CTR_WNT;
      {1'b1, CTR_WNT}: nxt = CTR_WT;
      {1'b1, CTR_WT }: nxt = CTR_ST;
      {1'b1, CTR_ST }: nxt = CTR_ST;
      {1'b0, CTR_SNT}: nxt = CTR_SNT;
      {1'b0, CTR_WNT}: nxt = CTR_SNT;
      {1'b0, CTR_WT }: nxt = CTR_WNT;
      {1'b0, CTR_ST }: nxt = CTR_WT;
      default:         nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/if_btb.sv
// if_btb: direct-mapped branch target buffer with 2-bit counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (clears valid bits)
//   lookup_pc                PC to predict (combinational lookup, pre-update contents)
//   lookup_taken/_target     prediction; target is 0 when not taken
//   upd_valid/_pc/_target/_taken  training port, applied at the rising edge
//                            (upd_target must already be aligned)
module if_btb
  import if_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned SHIFT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - SHIFT;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [XLEN-1:0]    target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];

  logic [IDX-1:0]   lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX-1:0]   up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             unused_s;

  assign lk_idx_s = lookup_pc[IDX+SHIFT-1:SHIFT];
  assign lk_tag_s = lookup_pc[XLEN-1:IDX+SHIFT];
  assign up_idx_s = upd_pc[IDX+SHIFT-1:SHIFT];
  assign up_tag_s = upd_pc[XLEN-1:IDX+SHIFT];
  assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
  // Low alignment bits of the PCs never reach the array.
  assign unused_s = ^{lookup_pc, upd_pc};

  // Lookup: predict taken only on a valid tag match with counter MSB set.
  always_comb begin
    lookup_taken  = 1'b0;
    lookup_target = '0;
    if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s) && ctr_r[lk_idx_s][1]) begin
      lookup_taken  = 1'b1;
      lookup_target = target_r[lk_idx_s];
    end else begin
      lookup_taken  = 1'b0;
      lookup_target = '0;
    end
  end

  // Valid bits: all cleared on reset, set when a taken miss allocates.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (upd_valid && !up_hit_s && upd_taken) begin
      valid_r[up_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Entry payload: counter/target training on hit, allocation on taken miss.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid) begin
      if (up_hit_s) begin
        ctr_r[up_idx_s] <= ctr_next(ctr_r[up_idx_s], upd_taken);
        if (upd_taken) begin
          target_r[up_idx_s] <= upd_target;
        end
      end else if (upd_taken) begin
        tag_r[up_idx_s]    <= up_tag_s;
        target_r[up_idx_s] <= upd_target;
        ctr_r[up_idx_s]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/if_pc_gen_btb.sv
// if_pc_gen_btb: fetch PC generator with BTB-based taken-branch prediction.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall                hold the PC
//   redirect_valid/_pc   execute-stage redirect (overrides stall)
//   upd_*                BTB training from execute
//   pc_o                 registered fetch PC
//   pred_taken_o/_target_o  combinational prediction for pc_o (target 0 if not taken)
//   fetch_valid_o        registered; low for one cycle after reset or redirect
module if_pc_gen_btb
  import if_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter int unsigned     INST_BYTES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            fetch_valid_o
);

  localparam int unsigned     SHIFT      = inst_shift(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << SHIFT) - XLEN'(1));

  logic [XLEN-1:0] pc_r;
  logic            fetch_valid_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] redirect_aligned_s;
  logic [XLEN-1:0] upd_target_aligned_s;

  assign redirect_aligned_s   = redirect_pc & ALIGN_MASK;
  assign upd_target_aligned_s = upd_target & ALIGN_MASK;

  if_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES),
    .SHIFT   (SHIFT)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_r),
    .lookup_taken  (pred_taken_o),
    .lookup_target (pred_target_o),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target_aligned_s),
    .upd_taken     (upd_taken)
  );

  // Next-PC priority: redirect, stall, prediction, sequential (wraps).
  always_comb begin
    pc_next_s = pc_r + XLEN'(INST_BYTES);
    if (redirect_valid) begin
      pc_next_s = redirect_aligned_s;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else if (pred_taken_o) begin
      pc_next_s = pred_target_o;
    end else begin
      pc_next_s = pc_r + XLEN'(INST_BYTES);
    end
  end

  // PC and fetch-valid registers; valid drops for the cycle after a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      fetch_valid_r <= 1'b0;
    end else begin
      pc_r          <= pc_next_s;
      fetch_valid_r <= !redirect_valid;
    end
  end

  assign pc_o          = pc_r;
  assign fetch_valid_o = fetch_valid_r;

endmodule

// File: tb/tb_if_pc_gen_btb.sv
// tb_if_pc_gen_btb: directed test of if_pc_gen_btb with RESET_PC=0x100.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge.
module tb_if_pc_gen_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        fetch_valid_o;

  int checks = 0;
  int errors = 0;

  if_pc_gen_btb #(
    .XLEN        (32),
    .RESET_PC    (32'h0000_0100),
    .BTB_ENTRIES (16),
    .INST_BYTES  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .pc_o           (pc_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .fetch_valid_o  (fetch_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
  endtask

  // Redirect to pc and hold it there (stall stays high afterwards).
  task automatic park(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    stall          = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0;
    @(negedge clk);
    tick();
    check_eq("rst_pc", pc_o, 32'h0000_0100);
    check_eq("rst_fv", {31'd0, fetch_valid_o}, 32'd0);
    check_eq("rst_pred", {31'd0, pred_taken_o}, 32'd0);

    // Free run after reset.
    rst = 1'b0;
    tick();
    check_eq("run1_pc", pc_o, 32'h0000_0104);
    check_eq("run1_fv", {31'd0, fetch_valid_o}, 32'd1);
    tick();
    check_eq("run2_pc", pc_o, 32'h0000_0108);
    check_eq("run2_fv", {31'd0, fetch_valid_o}, 32'd1);
    check_eq("run2_pred", {31'd0, pred_taken_o}, 32'd0);

    // Redirect beats stall; target gets aligned.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    check_eq("redir_pc", pc_o, 32'h0000_0200);
    check_eq("redir_fv", {31'd0, fetch_valid_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc", pc_o, 32'h0000_0200);
      check_eq("stall_fv", {31'd0, fetch_valid_o}, 32'd1);
    end

    // Train 0x10 -> 0x83 (stored aligned as 0x80), then fetch 0x10.
    train(32'h10, 32'h83, 1'b1);
    tick();
    upd_valid = 1'b0;
    check_eq("train_hold_pc", pc_o, 32'h0000_0200);
    redirect_valid = 1'b1; redirect_pc = 32'h10; stall = 1'b0;
    tick();
    redirect_valid = 1'b0;
    check_eq("hit_pc", pc_o, 32'h10);
    check_eq("hit_fv", {31'd0, fetch_valid_o}, 32'd0);
    check_eq("hit_pred", {31'd0, pred_taken_o}, 32'd1);
    check_eq("hit_tgt", pred_target_o, 32'h80);
    tick();
    check_eq("follow_pc", pc_o, 32'h80);
    check_eq("follow_fv", {31'd0, fetch_valid_o}, 32'd1);

    // Counter hysteresis on 0x10 (starts at weak taken).
    park(32'h10);
    check_eq("hy_start_pred", {31'd0, pred_taken_o}, 32'd1);
    train(32'h10, 32'h80, 1'b0); tick();
    check_eq("hy_wnt_pred", {31'd0, pred_taken_o}, 32'd0);
    check_eq("hy_wnt_tgt", pred_target_o, 32'h0);
    train(32'h10, 32'h80, 1'b1); tick();
    check_eq("hy_wt_pred", {31'd0, pred_taken_o}, 32'd1);
    train(32'h10, 32'h80, 1'b1); tick();
    train(32'h10, 32'h84, 1'b1); tick();
    train(32'h10, 32'h80, 1'b0); tick();
    check_eq("hy_st_nt_pred", {31'd0, pred_taken_o}, 32'd1);
    check_eq("hy_st_nt_tgt", pred_target_o, 32'h84);
    train(32'h10, 32'h80, 1'b0); tick();
    upd_valid = 1'b0;
    check_eq("hy_back_wnt_pred", {31'd0, pred_taken_o}, 32'd0);

    // Alias: 0x50 shares index 4 with 0x10 and evicts it.
    train(32'h50, 32'h120, 1'b1); tick();
    upd_valid = 1'b0;
    check_eq("alias_old_pred", {31'd0, pred_taken_o}, 32'd0);
    park(32'h50);
    check_eq("alias_new_pred", {31'd0, pred_taken_o}, 32'd1);
    check_eq("alias_new_tgt", pred_target_o, 32'h120);
    // Not-taken miss on 0x90 (same index) must not disturb the entry.
    train(32'h90, 32'h200, 1'b0); tick();
    upd_valid = 1'b0;
    check_eq("nt_miss_pred", {31'd0, pred_taken_o}, 32'd1);
    check_eq("nt_miss_tgt", pred_target_o, 32'h120);

    // PC wrap.
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_top_pc", pc_o, 32'hFFFF_FFFC);
    check_eq("wrap_top_pred", {31'd0, pred_taken_o}, 32'd0);
    tick();
    check_eq("wrap_pc", pc_o, 32'h0);

    // Same-cycle lookup and update: old prediction now, new one next cycle.
    park(32'h20);
    check_eq("rbw_pre_pred", {31'd0, pred_taken_o}, 32'd0);
    train(32'h20, 32'h300, 1'b1);
    #1;
    check_eq("rbw_same_pred", {31'd0, pred_taken_o}, 32'd0);
    tick();
    upd_valid = 1'b0;
    check_eq("rbw_next_pred", {31'd0, pred_taken_o}, 32'd1);
    check_eq("rbw_next_tgt", pred_target_o, 32'h300);

    // Reset discards redirect and update, and clears the BTB.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h50;
    train(32'h100, 32'h400, 1'b1);
    tick();
    rst = 1'b0; upd_valid = 1'b0; redirect_valid = 1'b0;
    check_eq("rst2_pc", pc_o, 32'h0000_0100);
    check_eq("rst2_fv", {31'd0, fetch_valid_o}, 32'd0);
    check_eq("rst2_pred", {31'd0, pred_taken_o}, 32'd0);
    park(32'h20);
    check_eq("rst2_clear_pred", {31'd0, pred_taken_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
